// File: rtl/solver_dispatch_pkg.sv
// Shared definitions for the solver job dispatcher.
// Slot-state encodings and result width.
package solver_dispatch_pkg;

    localparam int ITER_BITS = 16;

    localparam logic [0:0] SLOT_IDLE    = 1'b0;
    localparam logic [0:0] SLOT_RUNNING = 1'b1;

    function automatic logic is_running(input logic [0:0] st);
        return st == SLOT_RUNNING;
    endfunction

endpackage

// File: rtl/solver_dispatch_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr_i,
// wrapping modulo N. Purely combinational.
module solver_dispatch_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_i + IW'(k);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/solver_dispatch.sv
// Job scheduler between the pixel-job source and an array of solvers.
// Dispatches jobs round-robin and collects results round-robin.
module solver_dispatch
    import solver_dispatch_pkg::*;
#(
    parameter int NUM_SOLVERS       = 4,
    parameter int SOLVER_INDEX_BITS = 2,
    parameter int JOB_ID_BITS       = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             job_valid,
    input  logic [JOB_ID_BITS-1:0]           job_id,
    output logic                             job_ready,
    output logic [NUM_SOLVERS-1:0]           solver_start,
    output logic [JOB_ID_BITS-1:0]           solver_job_id,
    input  logic [NUM_SOLVERS-1:0]           solver_done,
    input  logic [ITER_BITS*NUM_SOLVERS-1:0] solver_iter,
    output logic [NUM_SOLVERS-1:0]           solver_ack,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [JOB_ID_BITS-1:0]           result_id,
    output logic [ITER_BITS-1:0]             result_iter,
    output logic [SOLVER_INDEX_BITS:0]       busy_count,
    output logic                             idle
);

    localparam int N  = NUM_SOLVERS;
    localparam int IW = SOLVER_INDEX_BITS;
    localparam int CW = SOLVER_INDEX_BITS + 1;

    logic [N-1:0]           slot_state_q;
    logic [N-1:0]           slot_state_d;
    logic [JOB_ID_BITS-1:0] slot_id_q [N];

    logic [IW-1:0] disp_ptr_q;
    logic [IW-1:0] disp_ptr_d;
    logic [IW-1:0] coll_ptr_q;
    logic [IW-1:0] coll_ptr_d;

    logic [N-1:0]           start_q;
    logic [JOB_ID_BITS-1:0] start_id_q;
    logic [N-1:0]           ack_q;

    logic                   res_valid_q;
    logic                   res_valid_d;
    logic [JOB_ID_BITS-1:0] res_id_q;
    logic [ITER_BITS-1:0]   res_iter_q;

    logic [CW-1:0] busy_q;
    logic [CW-1:0] busy_d;

    logic [N-1:0]         idle_req;
    logic [N-1:0]         coll_req;
    logic [ITER_BITS-1:0] iter_slot [N];

    logic [N-1:0]  disp_grant;
    logic [IW-1:0] disp_idx;
    logic          disp_any;
    logic [N-1:0]  coll_grant;
    logic [IW-1:0] coll_idx;
    logic          coll_any;

    logic dispatch_fire;
    logic load_en;
    logic collect_fire;

    // done from an IDLE slot never reaches the collect arbiter
    always_comb begin
        idle_req = '0;
        coll_req = '0;
        for (int i = 0; i < N; i++) begin
            idle_req[i]  = slot_state_q[i] == SLOT_IDLE;
            coll_req[i]  = is_running(slot_state_q[i]) & solver_done[i];
            iter_slot[i] = solver_iter[i*ITER_BITS +: ITER_BITS];
        end
    end

    solver_dispatch_rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_disp_arb (
        .req_i   (idle_req),
        .ptr_i   (disp_ptr_q),
        .grant_o (disp_grant),
        .idx_o   (disp_idx),
        .any_o   (disp_any)
    );

    solver_dispatch_rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_coll_arb (
        .req_i   (coll_req),
        .ptr_i   (coll_ptr_q),
        .grant_o (coll_grant),
        .idx_o   (coll_idx),
        .any_o   (coll_any)
    );

    assign job_ready     = disp_any;
    assign dispatch_fire = job_valid & disp_any;
    assign load_en       = ~res_valid_q | result_ready;
    assign collect_fire  = load_en & coll_any;

    always_comb begin
        slot_state_d = slot_state_q;
        for (int i = 0; i < N; i++) begin
            if (dispatch_fire && disp_grant[i]) begin
                slot_state_d[i] = SLOT_RUNNING;
            end
            if (collect_fire && coll_grant[i]) begin
                slot_state_d[i] = SLOT_IDLE;
            end
        end
    end

    always_comb begin
        disp_ptr_d = disp_ptr_q;
        coll_ptr_d = coll_ptr_q;
        if (dispatch_fire) begin
            disp_ptr_d = disp_idx + IW'(1);
        end
        if (collect_fire) begin
            coll_ptr_d = coll_idx + IW'(1);
        end
    end

    // pop and refill may happen in the same cycle
    always_comb begin
        res_valid_d = res_valid_q;
        if (collect_fire) begin
            res_valid_d = 1'b1;
        end else if (load_en) begin
            res_valid_d = 1'b0;
        end
    end

    always_comb begin
        unique case ({dispatch_fire, collect_fire})
            2'b10:   busy_d = busy_q + CW'(1);
            2'b01:   busy_d = busy_q - CW'(1);
            default: busy_d = busy_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_state_q <= '0;
            disp_ptr_q   <= '0;
            coll_ptr_q   <= '0;
            busy_q       <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            slot_state_q <= slot_state_d;
            disp_ptr_q   <= disp_ptr_d;
            coll_ptr_q   <= coll_ptr_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                slot_id_q[i] <= '0;
            end
        end else if (dispatch_fire) begin
            slot_id_q[disp_idx] <= job_id;
        end
    end

    // start and ack are single-cycle pulses following the handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q    <= '0;
            start_id_q <= '0;
            ack_q      <= '0;
        end else begin
            start_q <= dispatch_fire ? disp_grant : '0;
            ack_q   <= collect_fire ? coll_grant : '0;
            if (dispatch_fire) begin
                start_id_q <= job_id;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_id_q   <= '0;
            res_iter_q <= '0;
        end else if (collect_fire) begin
            res_id_q   <= slot_id_q[coll_idx];
            res_iter_q <= iter_slot[coll_idx];
        end
    end

    assign solver_start  = start_q;
    assign solver_job_id = start_id_q;
    assign solver_ack    = ack_q;
    assign result_valid  = res_valid_q;
    assign result_id     = res_id_q;
    assign result_iter   = res_iter_q;
    assign busy_count    = busy_q;
    assign idle          = (busy_q == '0) & ~res_valid_q;

endmodule

// File: tb/tb_solver_dispatch.sv
// Scoreboard bench for solver_dispatch: directed scenarios plus
// randomized traffic against a slot-level reference model.
module tb_solver_dispatch;

    localparam int N  = 4;
    localparam int JB = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            job_valid;
    logic [JB-1:0]   job_id;
    logic            job_ready;
    logic [N-1:0]    solver_start;
    logic [JB-1:0]   solver_job_id;
    logic [N-1:0]    solver_done;
    logic [16*N-1:0] solver_iter;
    logic [N-1:0]    solver_ack;
    logic            result_valid;
    logic            result_ready;
    logic [JB-1:0]   result_id;
    logic [15:0]     result_iter;
    logic [2:0]      busy_count;
    logic            idle;

    solver_dispatch #(
        .NUM_SOLVERS       (N),
        .SOLVER_INDEX_BITS (2),
        .JOB_ID_BITS       (JB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .job_valid     (job_valid),
        .job_id        (job_id),
        .job_ready     (job_ready),
        .solver_start  (solver_start),
        .solver_job_id (solver_job_id),
        .solver_done   (solver_done),
        .solver_iter   (solver_iter),
        .solver_ack    (solver_ack),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_id     (result_id),
        .result_iter   (result_iter),
        .busy_count    (busy_count),
        .idle          (idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        int slot;
        int id;
    } start_t;

    typedef struct {
        int id;
        int iter;
    } res_t;

    start_t exp_start[$];
    int     exp_ack[$];
    res_t   exp_res[$];

    int checks = 0;
    int errors = 0;

    bit [N-1:0] m_busy;
    int         m_id [N];
    int         m_dptr;
    int         m_cptr;
    bit         m_rv;

    bit run [N];
    int cnt [N];
    bit spur [N];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int first_from(input bit [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int busy_slots();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // reference model: slots, pointers and the held result
    always @(posedge clock or posedge reset) begin
        int ds;
        int cs;
        if (reset) begin
            m_busy = '0;
            m_dptr = 0;
            m_cptr = 0;
            m_rv   = 0;
            exp_start.delete();
            exp_ack.delete();
            exp_res.delete();
        end else begin
            ds = -1;
            cs = -1;
            if (job_valid && m_busy != '1) ds = first_from(~m_busy, m_dptr);
            if (!m_rv || result_ready) begin
                cs = first_from(m_busy & solver_done, m_cptr);
                if (cs >= 0) begin
                    exp_res.push_back('{m_id[cs], int'(solver_iter[16*cs +: 16])});
                    exp_ack.push_back(cs);
                    m_busy[cs] = 1'b0;
                    m_cptr = (cs + 1) % N;
                    m_rv = 1'b1;
                end else begin
                    m_rv = 1'b0;
                end
            end
            if (ds >= 0) begin
                m_busy[ds] = 1'b1;
                m_id[ds] = int'(job_id);
                exp_start.push_back('{ds, int'(job_id)});
                m_dptr = (ds + 1) % N;
            end
        end
    end

    // monitor: compares DUT outputs against the scoreboard queues
    always @(negedge clock) begin
        logic [N-1:0] es;
        logic [N-1:0] ea;
        int eid;
        int bc;
        start_t s;
        if (!reset) begin
            es = '0;
            ea = '0;
            eid = 0;
            if (exp_start.size() > 0) begin
                s = exp_start.pop_front();
                es[s.slot] = 1'b1;
                eid = s.id;
            end
            chk("solver_start", solver_start, es);
            if (es != '0) chk("solver_job_id", solver_job_id, eid);
            if (exp_ack.size() > 0) ea[exp_ack.pop_front()] = 1'b1;
            chk("solver_ack", solver_ack, ea);
            bc = busy_slots();
            chk("busy_count", busy_count, bc);
            chk("job_ready", job_ready, bc < N);
            chk("idle", idle, bc == 0 && !m_rv);
            chk("result_valid", result_valid, exp_res.size() > 0);
            if (exp_res.size() > 0) begin
                chk("result_id", result_id, exp_res[0].id);
                chk("result_iter", result_iter, exp_res[0].iter);
                if (result_ready) void'(exp_res.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_iter(input int i, input int v);
        solver_iter[16*i +: 16] = 16'(v);
    endtask

    task automatic solver_step();
        for (int i = 0; i < N; i++) begin
            if (solver_ack[i]) begin
                solver_done[i] = 1'b0;
                run[i] = 1'b0;
            end
            if (spur[i]) begin
                solver_done[i] = 1'b0;
                spur[i] = 1'b0;
            end
            if (solver_start[i]) begin
                run[i] = 1'b1;
                cnt[i] = int'($urandom_range(0, 6));
            end else if (run[i] && !solver_done[i]) begin
                if (cnt[i] == 0) begin
                    solver_done[i] = 1'b1;
                    set_iter(i, int'($urandom_range(0, 65535)));
                end else begin
                    cnt[i]--;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, solver_start, 0);
        chk({tag, "_job_id"}, solver_job_id, 0);
        chk({tag, "_ack"}, solver_ack, 0);
        chk({tag, "_rvalid"}, result_valid, 0);
        chk({tag, "_rid"}, result_id, 0);
        chk({tag, "_riter"}, result_iter, 0);
        chk({tag, "_busy"}, busy_count, 0);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_ready"}, job_ready, 1);
    endtask

    initial begin
        int guard;
        job_valid    = 1'b0;
        job_id       = '0;
        solver_done  = '0;
        solver_iter  = '0;
        result_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            run[i] = 0;
            cnt[i] = 0;
            spur[i] = 0;
        end

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // four back-to-back jobs fill every slot, fifth stalls
        step();
        job_valid = 1'b1;
        job_id = 16'd10;
        step();
        job_id = 16'd11;
        step();
        job_id = 16'd12;
        step();
        job_id = 16'd13;
        step();
        chk("full_job_ready", job_ready, 0);
        job_id = 16'd14;
        step();
        step();
        chk("stall_start", solver_start, 0);

        // slots 2 and 0 finish together; slot 0 wins from pointer 0
        solver_done = 4'b0101;
        set_iter(0, 3);
        set_iter(2, 7);
        result_ready = 1'b1;
        step();
        chk("first_ack", solver_ack, 4'b0001);
        chk("first_rid", result_id, 10);
        chk("first_riter", result_iter, 3);
        solver_done[0] = 1'b0;
        step();
        chk("second_ack", solver_ack, 4'b0100);
        chk("second_rid", result_id, 12);
        chk("second_riter", result_iter, 7);
        chk("redispatch_start", solver_start, 4'b0001);
        chk("redispatch_id", solver_job_id, 14);
        chk("both_busy", busy_count, 3);
        solver_done[2] = 1'b0;
        job_valid = 1'b0;
        step();

        // backpressure with three finished solvers
        result_ready = 1'b0;
        solver_done = 4'b1011;
        set_iter(0, 20);
        set_iter(1, 21);
        set_iter(3, 23);
        step();
        chk("hold_ack", solver_ack, 4'b1000);
        solver_done[3] = 1'b0;
        repeat (5) begin
            step();
            chk("hold_rid", result_id, 13);
            chk("hold_riter", result_iter, 23);
            chk("hold_noack", solver_ack, 0);
        end
        result_ready = 1'b1;
        step();
        solver_done[0] = 1'b0;
        step();
        solver_done[1] = 1'b0;
        step();
        chk("drained_idle", idle, 1);

        // reset while three slots run and a result is held
        job_valid = 1'b1;
        job_id = 16'd30;
        step();
        job_id = 16'd31;
        step();
        job_id = 16'd32;
        step();
        job_id = 16'd33;
        step();
        job_valid = 1'b0;
        result_ready = 1'b0;
        solver_done[1] = 1'b1;
        set_iter(1, 99);
        step();
        solver_done[1] = 1'b0;
        step();
        chk("pre_rst_rvalid", result_valid, 1);
        chk("pre_rst_busy", busy_count, 3);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        solver_done = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        job_valid = 1'b1;
        job_id = 16'd40;
        step();
        chk("post_rst_start", solver_start, 4'b0001);
        chk("post_rst_id", solver_job_id, 40);

        // randomized traffic
        for (int i = 0; i < N; i++) begin
            run[i] = 0;
            spur[i] = 0;
        end
        repeat (3000) begin
            solver_step();
            job_valid = ($urandom_range(0, 9) < 6);
            job_id = 16'($urandom_range(0, 65535));
            result_ready = ($urandom_range(0, 9) < 7);
            if (!job_valid) begin
                for (int i = 0; i < N; i++) begin
                    if (!m_busy[i] && !run[i] && !solver_done[i]
                        && $urandom_range(0, 7) == 0) begin
                        solver_done[i] = 1'b1;
                        set_iter(i, int'($urandom_range(0, 65535)));
                        spur[i] = 1'b1;
                    end
                end
            end
            step();
        end

        // drain with a bounded wait
        job_valid = 1'b0;
        result_ready = 1'b1;
        guard = 0;
        while ((m_busy != '0 || m_rv || exp_start.size() > 0)
               && guard < 300) begin
            solver_step();
            step();
            guard++;
        end
        solver_step();
        step();
        chk("drain_done", guard < 300, 1);
        @(negedge clock);
        chk("final_idle", idle, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
